// File: rtl/wideor_sched_pkg.sv
// Shared FSM type and width helpers for the chunked wide-OR scheduler.
package wideor_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of CHUNK-bit slices in a WIDTH-bit vector (guarded against CHUNK==0).
  function automatic int unsigned nchunk(input int unsigned width, input int unsigned chunk);
    return (chunk == 0) ? 32'd1 : width / chunk;
  endfunction

  // Bits needed to index n items; never narrower than one bit.
  function automatic int unsigned index_w(input int unsigned n);
    return (n > 1) ? 32'($clog2(n)) : 32'd1;
  endfunction

  // Width of the chunk index register.
  function automatic int unsigned idx_w(input int unsigned nch);
    return index_w(nch);
  endfunction

  // Width of the requester id field.
  function automatic int unsigned id_w(input int unsigned nreq);
    return index_w(nreq);
  endfunction

  // Width of the chunk count field, which must hold 1..nch.
  function automatic int unsigned cnt_w(input int unsigned nch);
    return (nch > 1) ? 32'($clog2(nch + 1)) : 32'd1;
  endfunction

endpackage

// File: rtl/wideor_rr_arb.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping.
module wideor_rr_arb
  import wideor_sched_pkg::*;
#(
  parameter int unsigned NREQ = 2,
  localparam int unsigned IDW = id_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_idx
);

  logic [IDW-1:0] cand;
  logic           found;

  // Walk the requesters starting at ptr; the first hit wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    cand    = '0;
    found   = 1'b0;
    for (int unsigned off = 0; off < NREQ; off++) begin
      cand = IDW'((32'(ptr) + off) % NREQ);
      if (!found && req[cand]) begin
        found   = 1'b1;
        gnt_idx = cand;
      end
    end
    if (found) begin
      gnt[gnt_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/wideor_sched.sv
// Arbitrates NREQ requesters onto one chunked OR-reduction engine and returns the result.
module wideor_sched
  import wideor_sched_pkg::*;
#(
  parameter int unsigned NREQ       = 2,
  parameter int unsigned WIDTH      = 128,
  parameter int unsigned CHUNK      = 32,
  parameter int unsigned EARLY_EXIT = 1,
  localparam int unsigned NCHUNK    = nchunk(WIDTH, CHUNK),
  localparam int unsigned IDXW      = idx_w(NCHUNK),
  localparam int unsigned IDW       = id_w(NREQ),
  localparam int unsigned CNTW      = cnt_w(NCHUNK)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic                  rsp_any,
  output logic [CNTW-1:0]       rsp_chunks
);

  // Reject configurations the chunk mux cannot tile.
  if ((CHUNK == 0) || ((WIDTH % ((CHUNK == 0) ? 1 : CHUNK)) != 0)) begin : g_chunk_check
    $error("wideor_sched: WIDTH (%0d) must be a non-zero multiple of CHUNK (%0d)", WIDTH, CHUNK);
  end
  if (NREQ < 1) begin : g_nreq_check
    $error("wideor_sched: NREQ must be at least 1");
  end

  state_t            state_q, state_d;
  logic              armed_q;
  logic [WIDTH-1:0]  data_q, data_d;
  logic              acc_q, acc_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic [IDW-1:0]    id_q, id_d;
  logic [IDW-1:0]    rr_ptr_q, rr_ptr_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]    rsp_id_q, rsp_id_d;
  logic              rsp_any_q, rsp_any_d;
  logic [CNTW-1:0]   rsp_chunks_q, rsp_chunks_d;

  logic [NREQ-1:0]   gnt;
  logic [IDW-1:0]    gnt_idx;
  logic [IDW-1:0]    next_ptr;
  logic [WIDTH-1:0]  req_vec [NREQ];
  logic [NCHUNK-1:0] chunk_hit;
  logic              cur_hit;
  logic              last_chunk;
  logic              grant_en;

  wideor_rr_arb #(
    .NREQ (NREQ)
  ) u_arb (
    .req     (req_valid),
    .ptr     (rr_ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // Split the flat request bus into per-requester vectors.
  for (genvar r = 0; r < NREQ; r++) begin : g_req
    assign req_vec[r] = req_data[r*WIDTH +: WIDTH];
  end

  // Per-chunk OR of the captured vector; the scan just selects one per cycle.
  for (genvar k = 0; k < NCHUNK; k++) begin : g_chunk
    assign chunk_hit[k] = |data_q[k*CHUNK +: CHUNK];
  end

  assign cur_hit    = chunk_hit[idx_q];
  assign last_chunk = (32'(idx_q) == (NCHUNK - 1)) || ((EARLY_EXIT != 0) && cur_hit);

  // A grant is only offered when idle, out of reset for at least one cycle, and something is asking.
  assign grant_en  = (state_q == IDLE) && armed_q && rst_n && (|req_valid);
  assign req_ready = grant_en ? gnt : '0;

  // Pointer moves just past the granted requester, wrapping at NREQ.
  always_comb begin
    next_ptr = '0;
    if ((32'(gnt_idx) + 32'd1) < NREQ) begin
      next_ptr = IDW'(32'(gnt_idx) + 32'd1);
    end
  end

  // Next-state and datapath update for the IDLE -> SCAN -> DONE sequence.
  always_comb begin
    state_d      = state_q;
    data_d       = data_q;
    acc_d        = acc_q;
    idx_d        = idx_q;
    id_d         = id_q;
    rr_ptr_d     = rr_ptr_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_any_d    = rsp_any_q;
    rsp_chunks_d = rsp_chunks_q;
    unique case (state_q)
      IDLE: begin
        if (grant_en) begin
          data_d   = req_vec[gnt_idx];
          id_d     = gnt_idx;
          acc_d    = 1'b0;
          idx_d    = '0;
          rr_ptr_d = next_ptr;
          state_d  = SCAN;
        end
      end
      SCAN: begin
        acc_d = acc_q | cur_hit;
        idx_d = idx_q + IDXW'(1);
        if (last_chunk) begin
          state_d      = DONE;
          rsp_valid_d  = 1'b1;
          rsp_id_d     = id_q;
          rsp_any_d    = acc_q | cur_hit;
          rsp_chunks_d = CNTW'(idx_q) + CNTW'(1);
        end
      end
      DONE: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, datapath and result registers with synchronous clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      armed_q      <= 1'b0;
      data_q       <= '0;
      acc_q        <= 1'b0;
      idx_q        <= '0;
      id_q         <= '0;
      rr_ptr_q     <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_any_q    <= 1'b0;
      rsp_chunks_q <= '0;
    end else begin
      state_q      <= state_d;
      armed_q      <= 1'b1;
      data_q       <= data_d;
      acc_q        <= acc_d;
      idx_q        <= idx_d;
      id_q         <= id_d;
      rr_ptr_q     <= rr_ptr_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_any_q    <= rsp_any_d;
      rsp_chunks_q <= rsp_chunks_d;
    end
  end

  // Outputs read zero for as long as reset is held.
  assign rsp_valid  = rsp_valid_q & rst_n;
  assign rsp_id     = rsp_id_q & {IDW{rst_n}};
  assign rsp_any    = rsp_any_q & rst_n;
  assign rsp_chunks = rsp_chunks_q & {CNTW{rst_n}};

endmodule

// File: tb/tb_wideor_sched.sv
// Bench for wideor_sched: two instances (early exit on/off) against a transaction-level model.
`timescale 1ns/1ps
module tb_wideor_sched;

  localparam int unsigned NREQ  = 2;
  localparam int unsigned WIDTH = 128;
  localparam int unsigned CHUNK = 32;
  localparam int unsigned NCH   = WIDTH / CHUNK;
  localparam int SLOTS = 512;
  localparam int NLOG  = 64;
  localparam int P_IDLE = 0;
  localparam int P_BUSY = 1;
  localparam int P_RESP = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic [NREQ-1:0]       req_valid  [2];
  logic [NREQ*WIDTH-1:0] req_data   [2];
  logic [NREQ-1:0]       req_ready  [2];
  logic                  rsp_valid  [2];
  logic                  rsp_ready  [2];
  logic [0:0]            rsp_id     [2];
  logic                  rsp_any    [2];
  logic [2:0]            rsp_chunks [2];

  always #5 clk = ~clk;

  wideor_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .CHUNK(CHUNK), .EARLY_EXIT(1)) u_ee (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[0]), .req_data(req_data[0]), .req_ready(req_ready[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_id(rsp_id[0]),
    .rsp_any(rsp_any[0]), .rsp_chunks(rsp_chunks[0])
  );

  wideor_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .CHUNK(CHUNK), .EARLY_EXIT(0)) u_full (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[1]), .req_data(req_data[1]), .req_ready(req_ready[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_id(rsp_id[1]),
    .rsp_any(rsp_any[1]), .rsp_chunks(rsp_chunks[1])
  );

  // Request streams shared by both instances; each instance consumes at its own pace.
  logic [WIDTH-1:0] stream [NREQ][SLOTS];
  int slen [NREQ];
  int pos  [2][NREQ];
  bit vld  [2][NREQ];
  int vmode;   // 0: raise valid as soon as an item is queued, 1: random
  int rmode;   // 0: rsp_ready high, 1: held low, 2: random
  bit rst_req;
  int cycle;

  // Transaction-level model state per instance.
  int m_phase [2];
  int m_rem [2];
  int m_ptr [2];
  int m_gnt [2];
  int m_id [2];
  int m_chunks [2];
  int m_gcycle [2];
  bit m_any [2];
  bit m_armed [2];
  bit m_rstprev;

  bit rv_prev [2];
  int rise [2];
  int lg_id [2][NLOG];
  int lg_ch [2][NLOG];
  int lg_lat [2][NLOG];
  int lg_any [2][NLOG];
  int nlog [2];

  int n_cmp;
  int n_bad;

  task automatic chk(input string name, input int i, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s inst%0d cycle %0d: got %0d expected %0d", name, i, cycle, act, exp);
    end
  endtask

  // Chunks examined: position of first non-zero chunk with early exit, else all of them.
  function automatic int ref_chunks(input logic [WIDTH-1:0] d, input bit ee);
    logic [WIDTH-1:0] s;
    if (!ee) return NCH;
    for (int k = 0; k < NCH; k++) begin
      s = d >> (k * CHUNK);
      if (s[CHUNK-1:0] != '0) return k + 1;
    end
    return NCH;
  endfunction

  function automatic logic [WIDTH-1:0] rnd_vec();
    logic [WIDTH-1:0] v;
    v = '0;
    for (int k = 0; k < NCH; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        if ($urandom_range(0, 1) == 0) v[k*CHUNK +: CHUNK] = $urandom;
        else v[k*CHUNK + int'($urandom_range(0, CHUNK-1))] = 1'b1;
      end
    end
    return v;
  endfunction

  task automatic push(input int r, input logic [WIDTH-1:0] d);
    if (slen[r] < SLOTS) begin
      stream[r][slen[r]] = d;
      slen[r]++;
    end
  endtask

  // Expected outputs for the current cycle, and result logging.
  task automatic compare(input int i);
    logic [NREQ-1:0] er;
    int g;
    int j;
    er = '0;
    g  = -1;
    if (rst_n && m_armed[i] && m_phase[i] == P_IDLE) begin
      for (int off = 0; off < NREQ; off++) begin
        j = (m_ptr[i] + off) % NREQ;
        if (g < 0 && vld[i][j]) g = j;
      end
    end
    if (g >= 0) er[g] = 1'b1;
    m_gnt[i] = g;
    chk("req_ready", i, longint'(req_ready[i]), longint'(er));
    if (!rst_n || m_rstprev) begin
      chk("rsp_valid_rst", i, longint'(rsp_valid[i]), 0);
      chk("rsp_id_rst", i, longint'(rsp_id[i]), 0);
      chk("rsp_any_rst", i, longint'(rsp_any[i]), 0);
      chk("rsp_chunks_rst", i, longint'(rsp_chunks[i]), 0);
    end else begin
      chk("rsp_valid", i, longint'(rsp_valid[i]), (m_phase[i] == P_RESP) ? 1 : 0);
      if (m_phase[i] == P_RESP) begin
        chk("rsp_id", i, longint'(rsp_id[i]), m_id[i]);
        chk("rsp_any", i, longint'(rsp_any[i]), longint'(m_any[i]));
        chk("rsp_chunks", i, longint'(rsp_chunks[i]), m_chunks[i]);
      end
    end
    if (rsp_valid[i] && !rv_prev[i]) rise[i] = cycle;
    if (rst_n && rsp_valid[i] && rsp_ready[i] && nlog[i] < NLOG) begin
      lg_id[i][nlog[i]]  = int'(rsp_id[i]);
      lg_ch[i][nlog[i]]  = int'(rsp_chunks[i]);
      lg_any[i][nlog[i]] = int'(rsp_any[i]);
      lg_lat[i][nlog[i]] = rise[i] - m_gcycle[i];
      nlog[i]++;
    end
    rv_prev[i] = rsp_valid[i];
  endtask

  // Effect of the clock edge on the model, from the inputs held during the cycle.
  task automatic advance(input int i);
    logic [WIDTH-1:0] d;
    int g;
    if (!rst_n) begin
      m_phase[i] = P_IDLE;
      m_ptr[i]   = 0;
      m_armed[i] = 1'b0;
    end else begin
      case (m_phase[i])
        P_IDLE: begin
          if (m_gnt[i] >= 0) begin
            g            = m_gnt[i];
            d            = stream[g][pos[i][g]];
            m_id[i]      = g;
            m_any[i]     = (d != '0);
            m_chunks[i]  = ref_chunks(d, i == 0);
            m_rem[i]     = m_chunks[i];
            m_ptr[i]     = (g + 1) % NREQ;
            m_gcycle[i]  = cycle;
            pos[i][g]++;
            vld[i][g]    = 1'b0;
            m_phase[i]   = P_BUSY;
          end
        end
        P_BUSY: begin
          m_rem[i]--;
          if (m_rem[i] == 0) m_phase[i] = P_RESP;
        end
        default: begin
          if (rsp_ready[i]) m_phase[i] = P_IDLE;
        end
      endcase
      m_armed[i] = 1'b1;
    end
  endtask

  task automatic cyc();
    rst_n = ~rst_req;
    for (int i = 0; i < 2; i++) begin
      for (int r = 0; r < NREQ; r++) begin
        if (!vld[i][r] && pos[i][r] < slen[r] && (vmode == 0 || $urandom_range(0, 2) == 0))
          vld[i][r] = 1'b1;
        req_valid[i][r] = vld[i][r];
        req_data[i][r*WIDTH +: WIDTH] = (pos[i][r] < slen[r]) ? stream[r][pos[i][r]] : '0;
      end
      rsp_ready[i] = (rmode == 0) ? 1'b1 : (rmode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    cycle++;
    for (int i = 0; i < 2; i++) compare(i);
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) advance(i);
    m_rstprev = ~rst_n;
  endtask

  function automatic bit all_idle();
    for (int i = 0; i < 2; i++) begin
      if (m_phase[i] != P_IDLE) return 1'b0;
      for (int r = 0; r < NREQ; r++)
        if (pos[i][r] < slen[r] || vld[i][r]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic run_until_idle(input int bound, input string tag);
    int n;
    n = 0;
    while (!all_idle() && n < bound) begin
      cyc();
      n++;
    end
    n_cmp++;
    if (!all_idle()) begin
      n_bad++;
      $display("FAIL %s_timeout: still busy after %0d cycles, required idle", tag, n);
    end
  endtask

  initial begin
    logic [WIDTH-1:0] v;
    int n;
    int rst_cnt;
    int exp_ch;
    n_cmp = 0;
    n_bad = 0;
    cycle = 0;
    vmode = 0;
    rmode = 0;
    rst_req = 1'b1;
    m_rstprev = 1'b1;
    for (int r = 0; r < NREQ; r++) slen[r] = 0;
    for (int i = 0; i < 2; i++) begin
      m_phase[i] = P_IDLE; m_rem[i] = 0; m_ptr[i] = 0; m_gnt[i] = -1; m_id[i] = 0;
      m_chunks[i] = 0; m_gcycle[i] = 0; m_any[i] = 1'b0; m_armed[i] = 1'b0;
      rv_prev[i] = 1'b0; rise[i] = 0; nlog[i] = 0;
      for (int r = 0; r < NREQ; r++) begin
        pos[i][r] = 0;
        vld[i][r] = 1'b0;
      end
    end

    repeat (3) cyc();
    rst_req = 1'b0;

    // All-zero, chunk-1 hit and top-bit vectors through requester 0.
    push(0, '0);
    v = '0; v[40] = 1'b1;
    push(0, v);
    v = '0; v[127] = 1'b1;
    push(0, v);
    run_until_idle(200, "directed");
    for (int i = 0; i < 2; i++) begin
      chk("dir_count", i, nlog[i], 3);
      for (int t = 0; t < 3; t++) begin
        if (t < nlog[i]) begin
          exp_ch = (i == 0 && t == 1) ? 2 : 4;
          chk("dir_chunks", i, lg_ch[i][t], exp_ch);
          chk("dir_any", i, lg_any[i][t], (t == 0) ? 0 : 1);
          chk("dir_latency", i, lg_lat[i][t], exp_ch + 1);
        end
      end
      nlog[i] = 0;
    end

    // Reset while a vector is mid-scan.
    push(0, '0);
    n = 0;
    while (pos[0][0] < slen[0] && n < 50) begin
      cyc();
      n++;
    end
    cyc();
    rst_req = 1'b1;
    cyc();
    cyc();
    rst_req = 1'b0;

    // Both requesters held valid: strict alternation starting from requester 0.
    for (int t = 0; t < 2; t++) begin
      push(0, rnd_vec());
      push(1, rnd_vec());
    end
    run_until_idle(200, "round_robin");
    for (int i = 0; i < 2; i++) begin
      chk("rr_count", i, nlog[i], 4);
      for (int t = 0; t < 4; t++)
        if (t < nlog[i]) chk("rr_id", i, lg_id[i][t], t % 2);
      nlog[i] = 0;
    end

    // Result held under backpressure with requester 1 waiting.
    rmode = 1;
    push(0, rnd_vec());
    push(1, rnd_vec());
    repeat (16) cyc();
    rmode = 0;
    run_until_idle(200, "backpressure");
    for (int i = 0; i < 2; i++) begin
      chk("bp_count", i, nlog[i], 2);
      for (int t = 0; t < 2; t++)
        if (t < nlog[i]) chk("bp_id", i, lg_id[i][t], t);
      nlog[i] = 0;
    end

    // Random traffic, random backpressure, occasional reset.
    for (int t = 0; t < 240; t++) begin
      push(0, rnd_vec());
      push(1, rnd_vec());
    end
    vmode = 1;
    rmode = 2;
    rst_cnt = 0;
    for (int c = 0; c < 3000; c++) begin
      if (rst_cnt == 0 && $urandom_range(0, 499) == 0) rst_cnt = 2;
      rst_req = (rst_cnt > 0);
      if (rst_cnt > 0) rst_cnt--;
      cyc();
    end
    rst_req = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
